// File: rtl/timer_pkg.sv
// Shared types and elaboration-time helpers for the Timer input front end.
package timer_pkg;

  typedef enum logic [2:0] {ARM, IDLE, WAITH, HELD, WAITL} btn_state_e;

  typedef struct packed {
    logic press;
    logic held;
  } btn_evt_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: synchronizer, debounce FSM and a single-cycle press pulse.
module button_debouncer
  import timer_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic     clockSignal,
  input  logic     resetN,
  input  logic     raw,
  output btn_evt_t evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  btn_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic                   pulse;

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], raw};

  assign s = sync[SYNC_STAGES-1];

  // ARM behaves like a held button: a press held across reset must be released first.
  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) begin
      state <= ARM;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        ARM:
          if (s)                    cnt <= '0;
          else if (cnt == CNT_LAST) begin state <= IDLE; cnt <= '0; end
          else                      cnt <= cnt + 1'b1;
        IDLE:
          if (s) begin state <= WAITH; cnt <= CNT_W'(1); end
        WAITH:
          if (!s)                   begin state <= IDLE; cnt <= '0; end
          else if (cnt == CNT_LAST) begin state <= HELD; cnt <= '0; pulse <= 1'b1; end
          else                      cnt <= cnt + 1'b1;
        HELD:
          if (!s) begin state <= WAITL; cnt <= CNT_W'(1); end
        WAITL:
          if (s)                    begin state <= HELD; cnt <= '0; end
          else if (cnt == CNT_LAST) begin state <= IDLE; cnt <= '0; end
          else                      cnt <= cnt + 1'b1;
        default: begin
          state <= ARM;
          cnt   <= '0;
        end
      endcase
    end

  assign evt = '{press: pulse, held: (state == HELD)};

endmodule

// File: rtl/timer_input_conditioner.sv
// Timer front end: three debounced buttons plus the base-rate tick divider.
// SPLIT_LONG_PRESS_EN adds a long-press pulse on splitOrReset.
module timer_input_conditioner
  import timer_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int TICK_HZ       = 100,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clockSignal,
  input  logic resetN,
  input  logic modeInputRaw,
  input  logic startOrStopRaw,
  input  logic splitOrResetRaw,
  output logic modeInputPulse,
  output logic startOrStopPulse,
  output logic splitOrResetPulse,
  output logic splitOrResetLong,
  output logic tick100Hz
);

  localparam int NUM_BTN     = 3;
  localparam int TICK_DIV    = CLK_HZ / TICK_HZ;
  localparam int DEB_CYCLES  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
  localparam int CNT_W       = clog2(max2(DEB_CYCLES, LONG_CYCLES)) + 1;
  localparam int TICK_W      = max2(clog2(TICK_DIV), 1);

  logic     [NUM_BTN-1:0] raw;
  btn_evt_t [NUM_BTN-1:0] evt;
  logic                   unused_held;

  assign raw = {splitOrResetRaw, startOrStopRaw, modeInputRaw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clockSignal(clockSignal),
      .resetN     (resetN),
      .raw        (raw[i]),
      .evt        (evt[i])
    );
  end

  assign modeInputPulse    = evt[0].press;
  assign startOrStopPulse  = evt[1].press;
  assign splitOrResetPulse = evt[2].press;

  // Registered tick: decode one count early so the pulse lands on TICK_DIV-1.
  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) begin
      tick_cnt  <= '0;
      tick100Hz <= 1'b0;
    end else begin
      tick100Hz <= (tick_cnt == TICK_W'(TICK_DIV - 2));
      if (tick_cnt == TICK_W'(TICK_DIV - 1)) tick_cnt <= '0;
      else                                   tick_cnt <= tick_cnt + 1'b1;
    end

`ifdef SPLIT_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign unused_held = ^{evt[0].held, evt[1].held};

  // hold_cnt==0 means idle; it restarts only from a press pulse, so a bounce back to HELD stays quiet.
  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) begin
      hold_cnt         <= '0;
      splitOrResetLong <= 1'b0;
    end else begin
      splitOrResetLong <= 1'b0;
      if (!evt[2].held)               hold_cnt <= '0;
      else if (evt[2].press)          hold_cnt <= CNT_W'(1);
      else if (hold_cnt == LONG_LAST) begin
        hold_cnt         <= '0;
        splitOrResetLong <= 1'b1;
      end
      else if (hold_cnt != '0)        hold_cnt <= hold_cnt + 1'b1;
    end
`else
  assign unused_held      = ^{evt[0].held, evt[1].held, evt[2].held};
  assign splitOrResetLong = 1'b0;
`endif

endmodule
